// File: rtl/zeroriscy_irq_ctrl_pkg.sv
// zeroriscy_irq_ctrl_pkg: shared widths, offsets and FSM states for the interrupt controller
package zeroriscy_irq_ctrl_pkg;
  localparam int IRQ_ID_W = 5;
  localparam logic [7:0] EXC_OFF_IRQ_BASE = 8'h00;
  typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_CLEAR} irq_state_t;
endpackage

// File: rtl/zeroriscy_irq_prio_enc.sv
// zeroriscy_irq_prio_enc: lowest-index-first priority encoder
module zeroriscy_irq_prio_enc
  import zeroriscy_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 32
) (
  input  logic [NUM_IRQ-1:0]  req_i,
  output logic                valid_o,
  output logic [IRQ_ID_W-1:0] idx_o
);
  assign valid_o = |req_i;
  // scan downwards so the lowest set index is the last one written
  always_comb begin
    idx_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) idx_o = req_i[i] ? IRQ_ID_W'(i) : idx_o;
  end
endmodule

// File: rtl/zeroriscy_irq_ctrl.sv
// zeroriscy_irq_ctrl: vectored interrupt controller with req/ack handshake towards the core
module zeroriscy_irq_ctrl
  import zeroriscy_irq_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ   = 32,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter bit                 SYNC_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic [NUM_IRQ-1:0]  irq_en_i,
  input  logic                m_ie_i,
  output logic                irq_req_o,
  output logic [4:0]          irq_id_o,
  output logic [7:0]          irq_offset_o,
  input  logic                irq_ack_i,
  input  logic                dbg_irq_trap_i,
  output logic                dbg_trap_o,
  input  logic                sw_clear_i,
  input  logic [4:0]          sw_clear_id_i,
  output logic [NUM_IRQ-1:0]  pending_o
);
  logic [NUM_IRQ-1:0]  s, prev_q, pend_q, pend_d, rise, clr, cand;
  logic [31:0]         cand_ext;
  logic [IRQ_ID_W-1:0] sel, id_q, id_d;
  logic                valid, any, ack_take, dbg_q, dbg_d;
  irq_state_t          state_q, state_d;
  if (SYNC_EN) begin : g_sync
    logic [NUM_IRQ-1:0] s1_q, s2_q;
    // two-flop synchroniser for asynchronous interrupt lines
    always_ff @(posedge clk) begin
      s1_q <= rst ? '0 : irq_i;
      s2_q <= rst ? '0 : s1_q;
    end
    assign s = s2_q;
  end else begin : g_nosync
    assign s = irq_i;
  end
  assign cand     = pending_o & irq_en_i;
  assign cand_ext = 32'(cand);
  assign any      = valid & m_ie_i;
  assign ack_take = (state_q == IRQ_REQ) & irq_ack_i;
  zeroriscy_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
    .req_i   (cand),
    .valid_o (valid),
    .idx_o   (sel)
  );
  // edge lines latch rising edges until acked or cleared (a new edge beats a clear); level lines follow the input
  always_comb begin
    rise = s & ~prev_q;
    for (int i = 0; i < NUM_IRQ; i++)
      clr[i] = (ack_take && id_q == IRQ_ID_W'(i)) || (sw_clear_i && sw_clear_id_i == IRQ_ID_W'(i));
    pend_d    = EDGE_MASK & (rise | (pend_q & ~clr));
    pending_o = (EDGE_MASK & (rise | pend_q)) | (~EDGE_MASK & s);
  end
  // request FSM: latch the winner in IDLE, hold it in REQ, one dead cycle in CLEAR
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    if (state_q == IRQ_IDLE && any) begin
      state_d = IRQ_REQ;
      id_d    = sel;
    end else if (state_q == IRQ_REQ)
      state_d = irq_ack_i ? IRQ_CLEAR : (!cand_ext[id_q] || !m_ie_i) ? IRQ_IDLE : IRQ_REQ;
    else if (state_q == IRQ_CLEAR)
      state_d = IRQ_IDLE;
    dbg_d = ack_take & dbg_irq_trap_i;
  end
  // state, latched id, edge history and pending registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IRQ_IDLE;
      id_q    <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      dbg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      prev_q  <= s;
      pend_q  <= pend_d;
      dbg_q   <= dbg_d;
    end
  end
  assign irq_req_o    = state_q == IRQ_REQ;
  assign irq_id_o     = id_q;
  assign irq_offset_o = EXC_OFF_IRQ_BASE + {1'b0, id_q, 2'b00};
  assign dbg_trap_o   = dbg_q;
endmodule

// File: tb/tb_zeroriscy_irq_ctrl.sv
// tb_zeroriscy_irq_ctrl: directed self-checking bench for the interrupt controller
module tb_zeroriscy_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] irq_i = '0;
  logic [15:0] irq_en_i = '0;
  logic        m_ie_i = 1'b0;
  logic        irq_req_o;
  logic [4:0]  irq_id_o;
  logic [7:0]  irq_offset_o;
  logic        irq_ack_i = 1'b0;
  logic        dbg_irq_trap_i = 1'b0;
  logic        dbg_trap_o;
  logic        sw_clear_i = 1'b0;
  logic [4:0]  sw_clear_id_i = '0;
  logic [15:0] pending_o;
  int          n_chk = 0;
  int          n_fail = 0;

  zeroriscy_irq_ctrl #(.NUM_IRQ(16), .EDGE_MASK(16'h0220), .SYNC_EN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_i          (irq_i),
    .irq_en_i       (irq_en_i),
    .m_ie_i         (m_ie_i),
    .irq_req_o      (irq_req_o),
    .irq_id_o       (irq_id_o),
    .irq_offset_o   (irq_offset_o),
    .irq_ack_i      (irq_ack_i),
    .dbg_irq_trap_i (dbg_irq_trap_i),
    .dbg_trap_o     (dbg_trap_o),
    .sw_clear_i     (sw_clear_i),
    .sw_clear_id_i  (sw_clear_id_i),
    .pending_o      (pending_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(2);
    chk("rst_req", 32'(irq_req_o), 0);
    chk("rst_id", 32'(irq_id_o), 0);
    chk("rst_off", 32'(irq_offset_o), 0);
    chk("rst_dbg", 32'(dbg_trap_o), 0);
    chk("rst_pend", 32'(pending_o), 0);
    rst = 0; irq_en_i = 16'hFFFF; m_ie_i = 1; irq_i = 16'h0008;
    tick(2);
    chk("lvl3_pend", 32'(pending_o), 32'h8);
    chk("lvl3_req_early", 32'(irq_req_o), 0);
    tick();
    chk("lvl3_req", 32'(irq_req_o), 1);
    chk("lvl3_id", 32'(irq_id_o), 3);
    chk("lvl3_off", 32'(irq_offset_o), 32'h0C);
    irq_ack_i = 1;
    tick();
    irq_ack_i = 0;
    chk("lvl3_clear", 32'(irq_req_o), 0);
    chk("lvl3_nodbg", 32'(dbg_trap_o), 0);
    tick();
    chk("lvl3_idle", 32'(irq_req_o), 0);
    tick();
    chk("lvl3_rereq", 32'(irq_req_o), 1);
    chk("lvl3_reid", 32'(irq_id_o), 3);
    irq_ack_i = 1; irq_i = 0;
    tick();
    irq_ack_i = 0;
    tick(3);
    chk("lvl3_gone_req", 32'(irq_req_o), 0);
    chk("lvl3_gone_pend", 32'(pending_o), 0);
    irq_i = 16'h0020;
    tick();
    irq_i = 0;
    tick();
    chk("edge5_pend", 32'(pending_o), 32'h20);
    tick();
    chk("edge5_req", 32'(irq_req_o), 1);
    chk("edge5_id", 32'(irq_id_o), 5);
    chk("edge5_off", 32'(irq_offset_o), 32'h14);
    chk("edge5_held", 32'(pending_o), 32'h20);
    irq_ack_i = 1;
    tick();
    irq_ack_i = 0;
    chk("edge5_cleared", 32'(pending_o), 0);
    tick(2);
    chk("edge5_norereq", 32'(irq_req_o), 0);
    irq_i = 16'h0084;
    tick(3);
    chk("prio_req", 32'(irq_req_o), 1);
    chk("prio_id2", 32'(irq_id_o), 2);
    irq_i = 16'h0086;
    tick(3);
    chk("prio_nopreempt", 32'(irq_id_o), 2);
    chk("prio_pend", 32'(pending_o), 32'h86);
    irq_ack_i = 1; irq_i = 16'h0082;
    tick();
    irq_ack_i = 0;
    tick(2);
    chk("prio_req1", 32'(irq_req_o), 1);
    chk("prio_id1", 32'(irq_id_o), 1);
    irq_ack_i = 1; irq_i = 16'h0080;
    tick();
    irq_ack_i = 0;
    tick(2);
    chk("prio_req7", 32'(irq_req_o), 1);
    chk("prio_id7", 32'(irq_id_o), 7);
    irq_ack_i = 1; irq_i = 0;
    tick();
    irq_ack_i = 0;
    tick(3);
    chk("prio_done", 32'(irq_req_o), 0);
    irq_i = 16'h0010;
    tick(3);
    chk("wd_req", 32'(irq_req_o), 1);
    chk("wd_id", 32'(irq_id_o), 4);
    m_ie_i = 0;
    tick();
    chk("wd_drop", 32'(irq_req_o), 0);
    chk("wd_pend", 32'(pending_o), 32'h10);
    m_ie_i = 1;
    tick();
    chk("wd_rereq", 32'(irq_req_o), 1);
    chk("wd_reid", 32'(irq_id_o), 4);
    irq_ack_i = 1; irq_i = 0;
    tick();
    irq_ack_i = 0;
    tick(3);
    m_ie_i = 0;
    irq_i = 16'h0200;
    tick();
    irq_i = 0;
    tick(2);
    chk("e9_pend", 32'(pending_o), 32'h200);
    irq_i = 16'h0200;
    tick(2);
    sw_clear_i = 1; sw_clear_id_i = 9;
    tick();
    sw_clear_i = 0;
    chk("e9_set_wins", 32'(pending_o), 32'h200);
    irq_i = 0;
    tick(2);
    sw_clear_i = 1; sw_clear_id_i = 9;
    tick();
    sw_clear_i = 0;
    chk("e9_swclr", 32'(pending_o), 0);
    irq_i = 16'h0200;
    tick();
    irq_i = 0;
    tick(2);
    chk("e9_pend2", 32'(pending_o), 32'h200);
    sw_clear_i = 1; sw_clear_id_i = 31;
    tick();
    sw_clear_i = 0;
    chk("e9_clr31_nop", 32'(pending_o), 32'h200);
    chk("e9_noreq", 32'(irq_req_o), 0);
    sw_clear_i = 1; sw_clear_id_i = 9;
    tick();
    sw_clear_i = 0;
    m_ie_i = 1; dbg_irq_trap_i = 1; irq_i = 16'h0001;
    tick(3);
    chk("dbg_req", 32'(irq_req_o), 1);
    chk("dbg_id0", 32'(irq_id_o), 0);
    chk("dbg_off0", 32'(irq_offset_o), 0);
    irq_ack_i = 1; irq_i = 0;
    tick();
    irq_ack_i = 0;
    chk("dbg_pulse", 32'(dbg_trap_o), 1);
    tick();
    chk("dbg_pulse_end", 32'(dbg_trap_o), 0);
    dbg_irq_trap_i = 0;
    tick(3);
    irq_i = 16'h0008;
    tick(3);
    chk("rstmid_req", 32'(irq_req_o), 1);
    rst = 1;
    tick();
    chk("rstmid_req0", 32'(irq_req_o), 0);
    chk("rstmid_id0", 32'(irq_id_o), 0);
    chk("rstmid_off0", 32'(irq_offset_o), 0);
    chk("rstmid_pend0", 32'(pending_o), 0);
    chk("rstmid_dbg0", 32'(dbg_trap_o), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/zeroriscy_irq_ctrl.md
Name: zeroriscy_irq_ctrl

Overview:
- Parametrised vectored interrupt controller between the external interrupt lines and the zero-riscy controller/CSR file.
- Latches up to NUM_IRQ level- or edge-triggered sources, applies the per-line mask and the global M-mode interrupt enable, and selects the highest-priority source (lowest index wins).
- Presents that source to the core through a req/ack handshake, with the ID and the vector offset (0x00..0x7C, inside the external-interrupt window below EXC_OFF_RST = 0x80) held stable.
- Generalises the fixed single EXC_PC_IRQ path to N channels, with per-channel trigger mode and a debug-trap option.

Parameters:
- NUM_IRQ, 32: number of interrupt lines, 1..32.
- EDGE_MASK, {NUM_IRQ{1'b0}}: bit i = 1 makes line i rising-edge triggered; 0 makes it level triggered.
- SYNC_EN, 1: 1 inserts a 2-flop synchroniser on irq_i; 0 means irq_i is already synchronous.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- irq_i  in  NUM_IRQ  raw interrupt lines
- irq_en_i  in  NUM_IRQ  per-line enable mask (from CSR)
- m_ie_i  in  1  global interrupt enable (mstatus.MIE)
- irq_req_o  out  1  interrupt request to controller
- irq_id_o  out  5  ID of requested line
- irq_offset_o  out  8  vector offset = {1'b0, irq_id_o, 2'b00}
- irq_ack_i  in  1  controller has taken the request (PC_EXCEPTION issued)
- dbg_irq_trap_i  in  1  debug setting bit DBG_SETS_IRQ
- dbg_trap_o  out  1  one-cycle pulse: interrupt accepted while debug trap is set
- sw_clear_i  in  1  software clear strobe
- sw_clear_id_i  in  5  line to clear
- pending_o  out  NUM_IRQ  raw pending vector (for CSR read-back)

Behaviour:
- Reset values:
  - all outputs 0; pending = 0; edge history = 0; synchroniser flops = 0; state = IDLE.
- Input path:
  - sync stage 0/2 flops, per SYNC_EN.
  - s = synchronised line; prev = s delayed by one cycle.
- Pending update, per line i, every cycle:
  - Level line: pending[i] = s[i], pure follow; ack and sw_clear are ignored because the source must deassert.
  - Edge line: set when s & ~prev. Cleared by an ack whose latched id == i, or by sw_clear_i with sw_clear_id_i == i.
  - Set and clear in the same cycle: set wins, so a new edge is never lost.
  - sw_clear_id_i >= NUM_IRQ: no effect.
- Candidate:
  - cand = pending & irq_en_i.
  - any = |cand & m_ie_i.
  - sel = lowest set index of cand (combinational priority encoder).
- FSM:
  - IDLE: when any = 1, latch id <= sel and go to REQ. irq_req_o rises the cycle after the pending bit is visible (latency 1 cycle after sync, i.e. 3 cycles from irq_i with SYNC_EN = 1).
  - REQ:
    - irq_req_o = 1; irq_id_o and irq_offset_o are frozen, and a higher-priority arrival does not preempt.
    - irq_ack_i = 1 -> CLEAR. If the ack arrives in the same cycle as a withdrawal, the ack wins.
    - Otherwise, if cand[id] = 0 or m_ie_i = 0 (withdrawal) -> IDLE; irq_req_o drops the next cycle.
  - CLEAR: irq_req_o = 0 for exactly one cycle, so the CSR has time to clear MIE; then -> IDLE.
- irq_ack_i while not in REQ: ignored.
- dbg_trap_o: 1-cycle pulse in the cycle after an ack taken with dbg_irq_trap_i = 1.
- irq_id_o and irq_offset_o keep their last value in IDLE/CLEAR; they are only meaningful while irq_req_o = 1.
- Reset mid-request: returns to IDLE with req = 0 next cycle, and all pending edges are lost.
- NUM_IRQ < 32: unused ID values are never produced.

Decomposition:
- Add to zeroriscy_defines:
  - IRQ_ID_W = 5
  - typedef enum IrqState_t {IRQ_IDLE, IRQ_REQ, IRQ_CLEAR}
  - EXC_OFF_IRQ_BASE = 8'h00
- Sub-module zeroriscy_irq_prio_enc (parametrised NUM_IRQ): lowest-index-first encoder, outputs valid + 5-bit index.
- Synchroniser inline (generate on SYNC_EN).

Test Plan:
- Level line 3 high, en[3] = 1, m_ie = 1, SYNC_EN = 1 -> irq_req_o = 1 at cycle 3, id = 3, offset = 0x0C. Ack -> req low 1 cycle (CLEAR). Line still high -> req again 1 cycle after CLEAR.
- Edge line 5 (EDGE_MASK bit5 = 1): single-cycle pulse -> pending_o[5] = 1. Ack -> pending_o[5] = 0, and no re-request after CLEAR.
- Lines 7 and 2 pending simultaneously -> id = 2 first. Line 1 rises while in REQ -> id stays 2 until ack. Next request is id = 1, then id = 7.
- Request for id = 4 active, then m_ie_i drops before ack -> irq_req_o = 0 next cycle, pending_o[4] still 1. m_ie_i returns -> re-request id = 4.
- Edge line 9 pending: sw_clear_i with id 9 in the same cycle as a new rising edge on 9 -> pending_o[9] stays 1. sw_clear with id 9 alone -> cleared. sw_clear id 31 with NUM_IRQ = 16 -> no change.
- dbg_irq_trap_i = 1, ack of id = 0 -> dbg_trap_o = 1 for exactly one cycle after the ack. rst asserted during REQ -> all outputs 0 next cycle.
